tube_display_arbiter: RTL and testbench
=======================================

# tube_display_arbiter

Owns the 8-digit seven-segment tube display and decides, every clock, which source drives the eight digit codes fed to `tubes_display`. It has four mode-owned sources (free play, auto play, learn, menu), selected by the top-level mode. It also has one transient popup channel (score, "GOOD", error text) that preempts the current source for a fixed hold time. When ownership changes between modes, it inserts a blanking gap so stale digits never flash.

## Interface
Parameters:
- `HOLD_CYCLES`, default 100_000_000: popup display time in clk cycles (1 s at 100 MHz); minimum 1.
- `GAP_CYCLES`, default 2_000_000: blank interval on a mode switch (20 ms); minimum 1.
- `BLANK`, default 8'h00: digit code that the downstream decoder renders as all segments off.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `mode` input 2: base owner select; 0 = free play, 1 = auto play, 2 = learn, 3 = menu.
- `frame0`..`frame3` input 64 each: source frames. Bits [63:56] are digit 7 (leftmost) and bits [7:0] are digit 0.
- `pop_req` input 1: popup request, level-sampled each cycle.
- `pop_frame` input 64: popup content, captured on acceptance.
- `pop_ack` output 1: one-cycle pulse confirming that a popup was accepted.
- `disp` output 64: registered digit codes to `tubes_display`, using the same packing as the source frames.
- `owner` output 3: current driver; 0–3 = mode source, 4 = popup, 5 = blank gap.
- `busy` output 1: high while a popup is displayed.

## Operation
- Registers:
  - FSM state in {SHOW, GAP, POP}.
  - `cur_mode` (2 bits).
  - Down-counter `timer`, wide enough for max(HOLD_CYCLES, GAP_CYCLES) − 1.
  - Popup latch (64 bits).
- Reset: state = SHOW, `cur_mode` = 0, `timer` = 0, `disp` = {8{BLANK}}, `owner` = 0, `busy` = 0, `pop_ack` = 0, popup latch = {8{BLANK}}.
- Priority on every edge: `rst` > `pop_req` > mode change > timer expiry.
- SHOW:
  - `disp` <= `frame[cur_mode]` (live tracking), and `owner` = `cur_mode`.
  - If `pop_req`: go to POP.
  - Else if `mode` ≠ `cur_mode`: `cur_mode` <= `mode`, `timer` <= GAP_CYCLES−1, go to GAP.
- GAP:
  - `disp` <= {8{BLANK}}, and `owner` = 5.
  - If `pop_req`: go to POP.
  - Else if `mode` ≠ `cur_mode`: `cur_mode` <= `mode` and restart `timer` <= GAP_CYCLES−1.
  - Else if `timer` == 0: go to SHOW.
  - Else decrement `timer`.
- POP entry, from any state including POP itself:
  - Latch `pop_frame`, `timer` <= HOLD_CYCLES−1, `pop_ack` <= 1.
  - `disp` <= `pop_frame`, `owner` = 4, `busy` = 1.
  - `cur_mode` is not updated.
- POP:
  - `disp` holds the latch, ignoring `frame*`.
  - If `pop_req`: re-accept (retrigger), replacing the content and restarting the hold.
  - Else if `timer` == 0: if `mode` ≠ `cur_mode`, take the GAP entry actions; otherwise go to SHOW.
  - Else decrement `timer`.
- `pop_ack` is high only on the cycle immediately after an accepting edge. Holding `pop_req` high continuously retriggers every cycle. Requesters must drop `pop_req` on `pop_ack`.

## Timing
- Every output is registered, so each decision is visible one cycle after the sampling edge.
- SHOW latency: a change on `frame[cur_mode]` appears on `disp` one cycle later.
- Popup: `disp` shows the popup for exactly HOLD_CYCLES cycles after acceptance (with no retrigger). The next cycle shows the source frame, or blank if the mode changed.
- Mode switch: exactly GAP_CYCLES blank cycles, then the new source. A mode change during GAP restarts the full gap.
- HOLD_CYCLES = 1 and GAP_CYCLES = 1 are legal and give single-cycle intervals.
- `rst` asserted mid-POP or mid-GAP: the next cycle shows the full reset values. The popup is discarded and no `pop_ack` is issued.
- When `pop_req` and a mode change occur on the same edge, the popup wins. The mode change is serviced at popup expiry.

## Test plan
- Reset, then mode = 0, frame0 = 64'h0102030405060708: `disp` = {8{BLANK}} on the reset cycle, then frame0 on the next cycle; `owner` = 0.
- HOLD = 4, one-cycle `pop_req` with `pop_frame` = 64'hAA..AA in SHOW: `pop_ack` = 1 for one cycle; `disp` = AA..AA for exactly 4 cycles, then frame0; `busy` = 1 for those 4 cycles.
- GAP = 3, mode 0→2 in SHOW: 3 cycles of BLANK with `owner` = 5, then frame2 with `owner` = 2. A second mode change at gap cycle 2 extends the blank to 5 total cycles.
- Simultaneous `pop_req` and mode 0→1: popup shown for 4 cycles, then 3 blank cycles, then frame1.
- Retrigger at popup cycle 3 with a new `pop_frame` = 64'h55..55: `disp` switches to 55..55 and the hold restarts (4 more cycles); a second `pop_ack` pulse is issued.
- `rst` at GAP cycle 1 and at POP cycle 2: next cycle `disp` = BLANK, `owner` = 0, `busy` = 0, `cur_mode` = 0.

Source files
------------

// File: rtl/tube_display_arbiter.sv
// Seven-segment tube display arbiter: picks one of four mode sources, a timed popup,
// or a blanking gap on mode switches. All outputs are registered.
module tube_display_arbiter #(
   parameter int         HOLD_CYCLES = 100_000_000,
   parameter int         GAP_CYCLES  = 2_000_000,
   parameter logic [7:0] BLANK       = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [63:0] frame0,
   input  logic [63:0] frame1,
   input  logic [63:0] frame2,
   input  logic [63:0] frame3,
   input  logic        pop_req,
   input  logic [63:0] pop_frame,
   output logic        pop_ack,
   output logic [63:0] disp,
   output logic [2:0]  owner,
   output logic        busy
);

   // state | meaning
   // SHOW  | disp tracks frame[cur_mode] live
   // GAP   | blank interval after a mode switch
   // POP   | popup latch shown for HOLD_CYCLES
   typedef enum logic [1:0] {SHOW, GAP, POP} state_t;

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
   localparam logic [63:0]   BLANK8    = {8{BLANK}};

   state_t        state;
   logic [1:0]    cur_mode;
   logic [TW-1:0] timer;
   logic [63:0]   pop_latch;
   logic [63:0]   cur_frame;

   always_comb begin
      cur_frame = frame0;
      case (cur_mode)
         2'd0: cur_frame = frame0;
         2'd1: cur_frame = frame1;
         2'd2: cur_frame = frame2;
         2'd3: cur_frame = frame3;
         default: cur_frame = frame0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SHOW;
         cur_mode  <= 2'd0;
         timer     <= '0;
         pop_latch <= BLANK8;
         disp      <= BLANK8;
         owner     <= 3'd0;
         busy      <= 1'b0;
         pop_ack   <= 1'b0;
      end else begin
         pop_ack <= 1'b0;
         if (pop_req) begin
            // Accept or retrigger; cur_mode is deliberately left alone so the
            // pending mode change is serviced when the popup expires.
            state     <= POP;
            pop_latch <= pop_frame;
            timer     <= HOLD_LOAD;
            pop_ack   <= 1'b1;
            disp      <= pop_frame;
            owner     <= 3'd4;
            busy      <= 1'b1;
         end else begin
            case (state)
               SHOW: begin
                  if (mode != cur_mode) begin
                     cur_mode <= mode;
                     timer    <= GAP_LOAD;
                     state    <= GAP;
                     disp     <= BLANK8;
                     owner    <= 3'd5;
                  end else begin
                     disp  <= cur_frame;
                     owner <= {1'b0, cur_mode};
                  end
                  busy <= 1'b0;
               end
               GAP: begin
                  busy <= 1'b0;
                  if (mode != cur_mode) begin
                     cur_mode <= mode;
                     timer    <= GAP_LOAD;
                     disp     <= BLANK8;
                     owner    <= 3'd5;
                  end else if (timer == '0) begin
                     state <= SHOW;
                     disp  <= cur_frame;
                     owner <= {1'b0, cur_mode};
                  end else begin
                     timer <= timer - 1'b1;
                     disp  <= BLANK8;
                     owner <= 3'd5;
                  end
               end
               POP: begin
                  if (timer == '0) begin
                     busy <= 1'b0;
                     if (mode != cur_mode) begin
                        cur_mode <= mode;
                        timer    <= GAP_LOAD;
                        state    <= GAP;
                        disp     <= BLANK8;
                        owner    <= 3'd5;
                     end else begin
                        state <= SHOW;
                        disp  <= cur_frame;
                        owner <= {1'b0, cur_mode};
                     end
                  end else begin
                     timer <= timer - 1'b1;
                     disp  <= pop_latch;
                     owner <= 3'd4;
                     busy  <= 1'b1;
                  end
               end
               default: begin
                  state <= SHOW;
                  disp  <= BLANK8;
                  owner <= 3'd0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tube_display_arbiter.sv
// Bench for tube_display_arbiter: directed test-plan steps then random traffic,
// all checked against a cycles-remaining reference model.
module tb_tube_display_arbiter;
   localparam int         HOLD = 4;
   localparam int         GAP  = 3;
   localparam logic [7:0] BL   = 8'h00;
   localparam logic [63:0] BLANK8 = {8{BL}};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic [63:0] frame0 = 64'h0102030405060708;
   logic [63:0] frame1 = 64'h1111111111111111;
   logic [63:0] frame2 = 64'h2222222222222222;
   logic [63:0] frame3 = 64'h3333333333333333;
   logic        pop_req = 1'b0;
   logic [63:0] pop_frame = '0;
   logic        pop_ack;
   logic [63:0] disp;
   logic [2:0]  owner;
   logic        busy;

   always #5 clk = ~clk;

   tube_display_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BLANK(BL)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .frame0(frame0), .frame1(frame1), .frame2(frame2), .frame3(frame3),
      .pop_req(pop_req), .pop_frame(pop_frame), .pop_ack(pop_ack),
      .disp(disp), .owner(owner), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // Model: how many more cycles the popup / blank gap will stay on screen.
   int          pop_left = 0;
   int          gap_left = 0;
   int          cur      = 0;
   logic [63:0] latch    = BLANK8;
   logic [63:0] e_disp;
   logic [2:0]  e_owner;
   logic        e_busy, e_ack;

   function automatic logic [63:0] src(int m);
      case (m)
         0: return frame0;
         1: return frame1;
         2: return frame2;
         default: return frame3;
      endcase
   endfunction

   task automatic model_step();
      e_ack = 1'b0;
      if (rst) begin
         pop_left = 0; gap_left = 0; cur = 0; latch = BLANK8;
      end else if (pop_req) begin
         latch = pop_frame; pop_left = HOLD; gap_left = 0; e_ack = 1'b1;
      end else if (pop_left > 0) begin
         pop_left--;
         if (pop_left == 0 && int'(mode) != cur) begin
            cur = int'(mode); gap_left = GAP;
         end
      end else if (int'(mode) != cur) begin
         cur = int'(mode); gap_left = GAP;
      end else if (gap_left > 0) begin
         gap_left--;
      end
      if (rst) begin
         e_disp = BLANK8; e_owner = 3'd0; e_busy = 1'b0;
      end else if (pop_left > 0) begin
         e_disp = latch; e_owner = 3'd4; e_busy = 1'b1;
      end else if (gap_left > 0) begin
         e_disp = BLANK8; e_owner = 3'd5; e_busy = 1'b0;
      end else begin
         e_disp = src(cur); e_owner = 3'(cur); e_busy = 1'b0;
      end
   endtask

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("disp", disp, e_disp);
      check("owner", 64'(owner), 64'(e_owner));
      check("busy", 64'(busy), 64'(e_busy));
      check("pop_ack", 64'(pop_ack), 64'(e_ack));
   endtask

   initial begin
      // reset, then frame0 follows
      rst = 1'b1; step(); step();
      check("reset_disp", disp, BLANK8);
      rst = 1'b0; step();
      check("frame0_live", disp, 64'h0102030405060708);
      frame0 = 64'h0A0B0C0D0E0F0102; step(); step();

      // single popup in SHOW
      pop_frame = {8{8'hAA}}; pop_req = 1'b1; step();
      check("pop_first", disp, {8{8'hAA}});
      pop_req = 1'b0;
      repeat (5) step();

      // mode switch with gap, then a mid-gap second switch
      mode = 2'd2; repeat (5) step();
      mode = 2'd0; step(); step();
      mode = 2'd3; repeat (7) step();

      // popup and mode change on the same edge
      pop_frame = 64'hDEADBEEF01234567; pop_req = 1'b1; mode = 2'd1; step();
      pop_req = 1'b0; repeat (9) step();

      // retrigger at popup cycle 3
      pop_frame = {8{8'hAA}}; pop_req = 1'b1; step();
      pop_req = 1'b0; step(); step();
      pop_frame = {8{8'h55}}; pop_req = 1'b1; step();
      check("retrig", disp, {8{8'h55}});
      pop_req = 1'b0; repeat (5) step();

      // reset during GAP and during POP
      mode = 2'd2; step();
      rst = 1'b1; step(); rst = 1'b0; mode = 2'd0; step(); step();
      pop_frame = 64'hCAFEF00DCAFEF00D; pop_req = 1'b1; step();
      pop_req = 1'b0; step();
      rst = 1'b1; step(); rst = 1'b0; step(); step();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         rst     = ($urandom_range(149) == 0);
         pop_req = ($urandom_range(9) == 0);
         pop_frame = {$urandom, $urandom};
         if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
               0: frame0 = {$urandom, $urandom};
               1: frame1 = {$urandom, $urandom};
               2: frame2 = {$urandom, $urandom};
               default: frame3 = {$urandom, $urandom};
            endcase
         end
         step();
      end
      rst = 1'b0; pop_req = 1'b0;
      repeat (10) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
